// File: rtl/capture_pkg.sv
// rtl/capture_pkg.sv - edge-mode type, default widths and edge qualifier shared by capture_multi_ts
// Imported by capture_channel and capture_multi_ts.
package capture_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  localparam int DEF_CHANNELS  = 4;
  localparam int DEF_FLT_WIDTH = 8;
  localparam int DEF_TS_WIDTH  = 24;

  function automatic logic edge_qualify(input edge_mode_t mode, input logic rise, input logic fall);
    case (mode)
      EDGE_RISE: return rise;
      EDGE_FALL: return fall;
      EDGE_BOTH: return rise | fall;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/capture_channel.sv
// rtl/capture_channel.sv - one capture channel: synchroniser, glitch filter, edge qualifier, holding register
// Timestamps come from the shared free-running counter owned by the top level.
module capture_channel
  import capture_pkg::*;
#(
  parameter int FLT_WIDTH = DEF_FLT_WIDTH,
  parameter int TS_WIDTH  = DEF_TS_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_ena,
  input  logic                 i_filt_ena,
  input  logic [FLT_WIDTH-1:0] i_flt_val,
  input  logic [1:0]           i_edge_mode,
  input  logic                 i_d,
  input  logic                 i_cap_ack,
  input  logic                 i_ovr_clr,
  input  logic [TS_WIDTH-1:0]  i_ts_now,
  output logic                 o_filtered,
  output logic                 o_edge_pulse,
  output logic                 o_cap_valid,
  output logic [TS_WIDTH-1:0]  o_cap_ts,
  output logic [TS_WIDTH-1:0]  o_cap_period,
  output logic                 o_cap_pol,
  output logic                 o_cap_first,
  output logic                 o_overrun
);

  logic [1:0]           r_sync;
  logic [FLT_WIDTH-1:0] r_cnt;
  logic                 r_filtered;
  logic                 r_prev;
  logic                 r_edge_pulse;
  logic                 r_cap_valid;
  logic [TS_WIDTH-1:0]  r_cap_ts;
  logic [TS_WIDTH-1:0]  r_cap_period;
  logic                 r_cap_pol;
  logic                 r_cap_first;
  logic                 r_overrun;
  logic [TS_WIDTH-1:0]  r_last_ts;
  logic                 r_seen;

  logic                 w_d_s;
  logic                 w_rise;
  logic                 w_fall;
  logic                 w_capture;
  edge_mode_t           w_mode;
  logic [TS_WIDTH-1:0]  w_period;

  assign w_d_s  = r_sync[1];
  assign w_mode = edge_mode_t'(i_edge_mode);
  assign w_rise = r_filtered & ~r_prev;
  assign w_fall = ~r_filtered & r_prev;

  // The edge is seen one cycle after filtered changes, so i_ts_now here is
  // already the value from the cycle in which filtered first showed the new level.
  assign w_capture = i_ena & edge_qualify(w_mode, w_rise, w_fall);
  assign w_period  = r_seen ? (i_ts_now - r_last_ts) : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[0], i_d};
    end
  end

  // >= lets a lowered threshold take effect on the very next mismatching cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_filtered <= 1'b0;
      r_prev     <= 1'b0;
    end else if (i_ena) begin
      r_prev <= r_filtered;
      if (w_d_s == r_filtered) begin
        r_cnt <= '0;
      end else if (r_cnt >= i_flt_val) begin
        r_filtered <= w_d_s;
        r_cnt      <= '0;
      end else if (i_filt_ena) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_edge_pulse <= 1'b0;
      r_cap_valid  <= 1'b0;
      r_cap_ts     <= '0;
      r_cap_period <= '0;
      r_cap_pol    <= 1'b0;
      r_cap_first  <= 1'b0;
      r_last_ts    <= '0;
      r_seen       <= 1'b0;
    end else begin
      r_edge_pulse <= w_capture;
      if (w_capture) begin
        r_cap_ts     <= i_ts_now;
        r_cap_period <= w_period;
        r_cap_first  <= ~r_seen;
        r_cap_pol    <= r_filtered;
        r_cap_valid  <= 1'b1;
        r_last_ts    <= i_ts_now;
        r_seen       <= 1'b1;
      end else if (i_cap_ack) begin
        r_cap_valid <= 1'b0;
      end
    end
  end

  // A same-cycle ack means the consumer took the old sample, so no data was lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_capture && r_cap_valid && !i_cap_ack) begin
      r_overrun <= 1'b1;
    end else if (i_ovr_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign o_filtered   = r_filtered;
  assign o_edge_pulse = r_edge_pulse;
  assign o_cap_valid  = r_cap_valid;
  assign o_cap_ts     = r_cap_ts;
  assign o_cap_period = r_cap_period;
  assign o_cap_pol    = r_cap_pol;
  assign o_cap_first  = r_cap_first;
  assign o_overrun    = r_overrun;

endmodule

// File: rtl/capture_multi_ts.sv
// rtl/capture_multi_ts.sv - multi-channel filtered edge capture with shared free-running timestamp
// Owns ts_now and slices the flat per-channel vectors onto capture_channel instances.
module capture_multi_ts
  import capture_pkg::*;
#(
  parameter int CHANNELS  = DEF_CHANNELS,
  parameter int FLT_WIDTH = DEF_FLT_WIDTH,
  parameter int TS_WIDTH  = DEF_TS_WIDTH
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_ena,
  input  logic [CHANNELS-1:0]           i_filt_ena,
  input  logic [CHANNELS*FLT_WIDTH-1:0] i_flt_val,
  input  logic [2*CHANNELS-1:0]         i_edge_mode,
  input  logic [CHANNELS-1:0]           i_d,
  input  logic [CHANNELS-1:0]           i_cap_ack,
  input  logic [CHANNELS-1:0]           i_ovr_clr,
  output logic [TS_WIDTH-1:0]           o_ts_now,
  output logic [CHANNELS-1:0]           o_filtered,
  output logic [CHANNELS-1:0]           o_edge_pulse,
  output logic [CHANNELS-1:0]           o_cap_valid,
  output logic [CHANNELS*TS_WIDTH-1:0]  o_cap_ts,
  output logic [CHANNELS*TS_WIDTH-1:0]  o_cap_period,
  output logic [CHANNELS-1:0]           o_cap_pol,
  output logic [CHANNELS-1:0]           o_cap_first,
  output logic [CHANNELS-1:0]           o_overrun
);

  logic [TS_WIDTH-1:0] r_ts_now;

  // Keeps counting while i_ena is low so periods stay referenced to real time.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ts_now <= '0;
    end else begin
      r_ts_now <= r_ts_now + 1'b1;
    end
  end

  assign o_ts_now = r_ts_now;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    capture_channel #(
      .FLT_WIDTH (FLT_WIDTH),
      .TS_WIDTH  (TS_WIDTH)
    ) u_ch (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_ena        (i_ena),
      .i_filt_ena   (i_filt_ena[g]),
      .i_flt_val    (i_flt_val[g*FLT_WIDTH +: FLT_WIDTH]),
      .i_edge_mode  (i_edge_mode[2*g +: 2]),
      .i_d          (i_d[g]),
      .i_cap_ack    (i_cap_ack[g]),
      .i_ovr_clr    (i_ovr_clr[g]),
      .i_ts_now     (r_ts_now),
      .o_filtered   (o_filtered[g]),
      .o_edge_pulse (o_edge_pulse[g]),
      .o_cap_valid  (o_cap_valid[g]),
      .o_cap_ts     (o_cap_ts[g*TS_WIDTH +: TS_WIDTH]),
      .o_cap_period (o_cap_period[g*TS_WIDTH +: TS_WIDTH]),
      .o_cap_pol    (o_cap_pol[g]),
      .o_cap_first  (o_cap_first[g]),
      .o_overrun    (o_overrun[g])
    );
  end

endmodule

// File: tb/tb_capture_multi_ts.sv
// tb/tb_capture_multi_ts.sv - self-checking bench for capture_multi_ts
// Directed scenarios against constants, then random traffic against a history-based reference model.
module tb_capture_multi_ts;

  localparam int CH   = 4;
  localparam int FW   = 8;
  localparam int TW   = 8;
  localparam int HMAX = 4096;
  localparam int TMOD = 1 << TW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena;
  logic [CH-1:0]    filt_ena, d, cap_ack, ovr_clr;
  logic [CH*FW-1:0] flt_val;
  logic [2*CH-1:0]  edge_mode;
  logic [TW-1:0]    ts_now;
  logic [CH-1:0]    filtered, edge_pulse, cap_valid, cap_pol, cap_first, overrun;
  logic [CH*TW-1:0] cap_ts, cap_period;

  always #5 clk = ~clk;

  capture_multi_ts #(.CHANNELS(CH), .FLT_WIDTH(FW), .TS_WIDTH(TW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena), .i_filt_ena(filt_ena), .i_flt_val(flt_val),
    .i_edge_mode(edge_mode), .i_d(d), .i_cap_ack(cap_ack), .i_ovr_clr(ovr_clr),
    .o_ts_now(ts_now), .o_filtered(filtered), .o_edge_pulse(edge_pulse), .o_cap_valid(cap_valid),
    .o_cap_ts(cap_ts), .o_cap_period(cap_period), .o_cap_pol(cap_pol), .o_cap_first(cap_first),
    .o_overrun(overrun)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: k counts clock edges since reset release; d history gives the
  // synchronised level two edges later, and the filter flips when a whole window of
  // flt_val+1 samples after the last flip disagrees with the current level.
  int k;
  bit dh [CH][HMAX];
  bit m_filt [CH], m_pend [CH], m_pulse [CH], m_valid [CH];
  bit m_pol [CH], m_first [CH], m_ovr [CH], m_seen [CH];
  int m_chg [CH], m_ts [CH], m_per [CH], m_last [CH];

  function automatic bit ds_at(int c, int j);
    if (j < 2 || j - 2 >= HMAX) return 1'b0;
    return dh[c][j-2];
  endfunction

  task automatic model_reset();
    k = 0;
    for (int c = 0; c < CH; c++) begin
      m_filt[c] = 0; m_pend[c] = 0; m_pulse[c] = 0; m_valid[c] = 0;
      m_pol[c] = 0; m_first[c] = 0; m_ovr[c] = 0; m_seen[c] = 0;
      m_chg[c] = -1; m_ts[c] = 0; m_per[c] = 0; m_last[c] = 0;
      for (int j = 0; j < HMAX; j++) dh[c][j] = 0;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < CH; c++) begin
      int flt, t;
      logic [1:0] md;
      bit cap, all_diff;
      flt = int'(flt_val[c*FW +: FW]);
      md  = edge_mode[2*c +: 2];
      cap = m_pend[c] && (md == 2'b11 || (md == 2'b01 && m_filt[c]) || (md == 2'b10 && !m_filt[c]));
      m_pulse[c] = cap;
      if (cap && m_valid[c] && !cap_ack[c]) m_ovr[c] = 1;
      else if (ovr_clr[c]) m_ovr[c] = 0;
      if (cap) begin
        t = k % TMOD;
        m_per[c]   = m_seen[c] ? (t - m_last[c] + TMOD) % TMOD : 0;
        m_first[c] = !m_seen[c];
        m_ts[c]    = t;
        m_last[c]  = t;
        m_seen[c]  = 1;
        m_pol[c]   = m_filt[c];
        m_valid[c] = 1;
      end else if (cap_ack[c]) begin
        m_valid[c] = 0;
      end
      if (k < HMAX) dh[c][k] = d[c];
      m_pend[c] = 0;
      if (k - flt > m_chg[c]) begin
        all_diff = 1;
        for (int j = k - flt; j <= k; j++) if (ds_at(c, j) == m_filt[c]) all_diff = 0;
        if (all_diff) begin
          m_filt[c] = !m_filt[c];
          m_chg[c]  = k;
          m_pend[c] = 1;
        end
      end
    end
    k++;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(int target);
    while (k < target) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ena = 1'b1; filt_ena = '1; d = '0; cap_ack = '0; ovr_clr = '0;
    flt_val = '0; edge_mode = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic set_ch(int c, int flt, logic [1:0] mode);
    flt_val[c*FW +: FW] = FW'(flt);
    edge_mode[2*c +: 2] = mode;
  endtask

  function automatic logic [2*TW-1:0] cap_of(int c);
    return {cap_ts[c*TW +: TW], cap_period[c*TW +: TW]};
  endfunction

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({ts_now, filtered, edge_pulse, cap_valid, cap_ts, cap_period, cap_pol, cap_first, overrun} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got ts=%h filt=%b val=%b ovr=%b exp all zero", ts_now, filtered, cap_valid, overrun);
    end
    step();
    vectors++;
    if (ts_now !== TW'(1)) begin
      miscompares++;
      $display("FAIL reset_first_count: got ts=%0d exp 1", ts_now);
    end
  endtask

  task automatic test_first_rise();
    do_reset();
    set_ch(0, 3, 2'b01);
    d[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 5) begin
        vectors++;
        if ({filtered[0], cap_valid[0]} !== 2'b00) begin
          miscompares++;
          $display("FAIL first_rise cyc5: got filt/val=%b exp 00", {filtered[0], cap_valid[0]});
        end
      end
      if (i == 6) begin
        vectors++;
        if ({filtered[0], cap_valid[0], edge_pulse[0]} !== 3'b100) begin
          miscompares++;
          $display("FAIL first_rise cyc6: got filt/val/pulse=%b exp 100", {filtered[0], cap_valid[0], edge_pulse[0]});
        end
      end
      if (i == 7) begin
        vectors++;
        if ({filtered[0], cap_valid[0], edge_pulse[0], cap_first[0], cap_pol[0]} !== 5'b11111) begin
          miscompares++;
          $display("FAIL first_rise cyc7 flags: got %b exp 11111",
                   {filtered[0], cap_valid[0], edge_pulse[0], cap_first[0], cap_pol[0]});
        end
        vectors++;
        if (cap_of(0) !== {8'd6, 8'd0}) begin
          miscompares++;
          $display("FAIL first_rise cyc7 ts/period: got %h exp 0600", cap_of(0));
        end
      end
      if (i == 8) begin
        vectors++;
        if ({edge_pulse[0], cap_valid[0]} !== 2'b01) begin
          miscompares++;
          $display("FAIL first_rise cyc8: got pulse/val=%b exp 01", {edge_pulse[0], cap_valid[0]});
        end
      end
    end
  endtask

  task automatic test_glitch();
    bit seen_hi;
    do_reset();
    set_ch(0, 3, 2'b01);
    seen_hi = 0;
    d[0] = 1'b1;
    repeat (3) begin step(); seen_hi |= filtered[0] | edge_pulse[0]; end
    d[0] = 1'b0;
    repeat (8) begin step(); seen_hi |= filtered[0] | edge_pulse[0]; end
    vectors++;
    if (seen_hi !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_3cyc: got activity=%b exp 0", seen_hi);
    end
    d[0] = 1'b1;
    repeat (4) begin step(); seen_hi |= filtered[0]; end
    d[0] = 1'b0;
    repeat (12) begin step(); seen_hi |= filtered[0]; end
    vectors++;
    if ({seen_hi, filtered[0], cap_valid[0], cap_pol[0]} !== 4'b1011) begin
      miscompares++;
      $display("FAIL glitch_4cyc: got seen/filt/val/pol=%b exp 1011", {seen_hi, filtered[0], cap_valid[0], cap_pol[0]});
    end
  endtask

  task automatic test_period();
    do_reset();
    set_ch(1, 0, 2'b11);
    run_to(97);
    d[1] = 1'b1;
    repeat (4) step();
    vectors++;
    if ({cap_of(1), cap_valid[1], cap_first[1], cap_pol[1]} !== {8'd100, 8'd0, 3'b111}) begin
      miscompares++;
      $display("FAIL period_first: got ts/per=%h vfp=%b exp 6400 111", cap_of(1), {cap_valid[1], cap_first[1], cap_pol[1]});
    end
    cap_ack[1] = 1'b1; step(); cap_ack[1] = 1'b0;
    vectors++;
    if (cap_valid[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL period_ack: got valid=%b exp 0", cap_valid[1]);
    end
    run_to(347);
    d[1] = 1'b0;
    repeat (4) step();
    vectors++;
    if ({cap_of(1), cap_valid[1], cap_first[1], cap_pol[1]} !== {8'd94, 8'd250, 3'b100}) begin
      miscompares++;
      $display("FAIL period_second: got ts/per=%h vfp=%b exp 5efa 100", cap_of(1), {cap_valid[1], cap_first[1], cap_pol[1]});
    end
  endtask

  task automatic test_wrap();
    do_reset();
    set_ch(1, 0, 2'b11);
    run_to(247);
    d[1] = 1'b1;
    repeat (4) step();
    cap_ack[1] = 1'b1; step(); cap_ack[1] = 1'b0;
    run_to(257);
    d[1] = 1'b0;
    repeat (4) step();
    vectors++;
    if ({cap_of(1), cap_first[1]} !== {8'd4, 8'd10, 1'b0}) begin
      miscompares++;
      $display("FAIL wrap_period: got ts/per=%h first=%b exp 040a 0", cap_of(1), cap_first[1]);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    set_ch(2, 0, 2'b01);
    run_to(10);
    d[2] = 1'b1; repeat (4) step();
    d[2] = 1'b0; repeat (4) step();
    d[2] = 1'b1; repeat (4) step();
    vectors++;
    if ({cap_of(2), cap_valid[2], overrun[2]} !== {8'd21, 8'd8, 2'b11}) begin
      miscompares++;
      $display("FAIL overrun_set: got ts/per=%h val/ovr=%b exp 1508 11", cap_of(2), {cap_valid[2], overrun[2]});
    end
    ovr_clr[2] = 1'b1; step(); ovr_clr[2] = 1'b0;
    vectors++;
    if ({cap_valid[2], overrun[2]} !== 2'b10) begin
      miscompares++;
      $display("FAIL overrun_clear: got val/ovr=%b exp 10", {cap_valid[2], overrun[2]});
    end
    d[2] = 1'b0; repeat (4) step();
    d[2] = 1'b1; repeat (3) step();
    cap_ack[2] = 1'b1; step(); cap_ack[2] = 1'b0;
    vectors++;
    if ({cap_ts[2*TW +: TW], cap_valid[2], overrun[2]} !== {8'd30, 2'b10}) begin
      miscompares++;
      $display("FAIL overrun_ack_same_cycle: got ts=%0d val/ovr=%b exp 30 10", cap_ts[2*TW +: TW], {cap_valid[2], overrun[2]});
    end
    d[2] = 1'b0; repeat (4) step();
    d[2] = 1'b1; repeat (3) step();
    ovr_clr[2] = 1'b1; step(); ovr_clr[2] = 1'b0;
    vectors++;
    if ({cap_ts[2*TW +: TW], overrun[2]} !== {8'd38, 1'b1}) begin
      miscompares++;
      $display("FAIL overrun_set_beats_clear: got ts=%0d ovr=%b exp 38 1", cap_ts[2*TW +: TW], overrun[2]);
    end
    cap_ack[2] = 1'b1; step(); step(); cap_ack[2] = 1'b0;
    ovr_clr[2] = 1'b1; step(); ovr_clr[2] = 1'b0;
    vectors++;
    if ({cap_valid[2], overrun[2]} !== 2'b00) begin
      miscompares++;
      $display("FAIL overrun_final: got val/ovr=%b exp 00", {cap_valid[2], overrun[2]});
    end
  endtask

  task automatic test_mode_change();
    bit any_pulse;
    do_reset();
    set_ch(0, 0, 2'b00);
    any_pulse = 0;
    d[0] = 1'b1; repeat (4) begin step(); any_pulse |= edge_pulse[0]; end
    set_ch(0, 0, 2'b01); repeat (3) begin step(); any_pulse |= edge_pulse[0]; end
    d[0] = 1'b0; repeat (4) begin step(); any_pulse |= edge_pulse[0]; end
    set_ch(0, 0, 2'b10);
    d[0] = 1'b1; repeat (4) begin step(); any_pulse |= edge_pulse[0]; end
    vectors++;
    if ({any_pulse, cap_valid[0], filtered[0]} !== 3'b001) begin
      miscompares++;
      $display("FAIL mode_unqualified: got pulse/val/filt=%b exp 001", {any_pulse, cap_valid[0], filtered[0]});
    end
    d[0] = 1'b0; repeat (4) step();
    vectors++;
    if ({cap_valid[0], cap_first[0], cap_pol[0], cap_period[0 +: TW]} !== {3'b110, 8'd0}) begin
      miscompares++;
      $display("FAIL mode_first_qualified: got vfp=%b per=%0d exp 110 0", {cap_valid[0], cap_first[0], cap_pol[0]}, cap_period[0 +: TW]);
    end
  endtask

  task automatic test_ena_freeze();
    bit any_act;
    do_reset();
    set_ch(3, 3, 2'b01);
    d[3] = 1'b1; repeat (4) step();
    ena = 1'b0;
    any_act = 0;
    repeat (10) begin step(); any_act |= filtered[3] | edge_pulse[3]; end
    vectors++;
    if (any_act !== 1'b0) begin
      miscompares++;
      $display("FAIL ena_frozen: got activity=%b exp 0", any_act);
    end
    ena = 1'b1;
    step();
    vectors++;
    if (filtered[3] !== 1'b0) begin
      miscompares++;
      $display("FAIL ena_resume_hold: got filt=%b exp 0", filtered[3]);
    end
    step();
    step();
    vectors++;
    if ({filtered[3], edge_pulse[3], cap_valid[3]} !== 3'b111) begin
      miscompares++;
      $display("FAIL ena_resume_edge: got filt/pulse/val=%b exp 111", {filtered[3], edge_pulse[3], cap_valid[3]});
    end
    ena = 1'b0;
    cap_ack[3] = 1'b1; step(); cap_ack[3] = 1'b0;
    vectors++;
    if ({cap_valid[3], edge_pulse[3]} !== 2'b00) begin
      miscompares++;
      $display("FAIL ena_low_ack: got val/pulse=%b exp 00", {cap_valid[3], edge_pulse[3]});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_ch(0, 0, 2'b01);
    set_ch(1, 5, 2'b01);
    d[0] = 1'b1; repeat (5) step();
    d[1] = 1'b1; repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ts_now, filtered, edge_pulse, cap_valid, cap_ts, cap_period, cap_pol, cap_first, overrun} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_async: got ts=%h filt=%b val=%b exp all zero", ts_now, filtered, cap_valid);
    end
    do_reset();
    set_ch(0, 0, 2'b01);
    d[0] = 1'b1; repeat (5) step();
    vectors++;
    if ({cap_valid[0], cap_first[0], cap_of(0)} !== {2'b11, 8'd3, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_mid_first: got val/first=%b ts/per=%h exp 11 0300", {cap_valid[0], cap_first[0]}, cap_of(0));
    end
  endtask

  task automatic test_random();
    logic [2*TW+5:0] got, exp;
    do_reset();
    for (int c = 0; c < CH; c++) set_ch(c, $urandom_range(0, 4), 2'($urandom_range(0, 3)));
    for (int n = 0; n < 2000; n++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 5) == 0) d[c] = ~d[c];
        cap_ack[c] = ($urandom_range(0, 3) == 0);
        ovr_clr[c] = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 99) == 0) edge_mode[2*c +: 2] = 2'($urandom_range(0, 3));
      end
      step();
      vectors++;
      if (ts_now !== TW'(k % TMOD)) begin
        miscompares++;
        $display("FAIL random ts_now edge %0d: got %0d exp %0d", k, ts_now, k % TMOD);
      end
      for (int c = 0; c < CH; c++) begin
        got = {filtered[c], edge_pulse[c], cap_valid[c], overrun[c], cap_pol[c], cap_first[c], cap_of(c)};
        exp = {m_filt[c], m_pulse[c], m_valid[c], m_ovr[c], m_pol[c], m_first[c], TW'(m_ts[c]), TW'(m_per[c])};
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL random ch%0d edge %0d: got %h exp %h (filt,pulse,val,ovr,pol,first,ts,per)", c, k, got, exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_rise();
    test_glitch();
    test_period();
    test_wrap();
    test_overrun();
    test_mode_change();
    test_ena_freeze();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
